// File: rtl/fir_sample_packer.sv
// fir_sample_packer: FIFO-buffers 16-bit filtered samples and streams them MSB-first as bytes over valid/ready.
// Optional macro SYNC_HEADER_EN inserts an A5 5A header before the first sample and every FRAME_LEN-th sample.
module fir_sample_packer #(
  parameter int DATA_W = 16,
  parameter int DEPTH = 16,
  parameter int ADDR_W = 4
`ifdef SYNC_HEADER_EN
  , parameter int FRAME_LEN = 64
`endif
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              In_valid,
  input  logic [DATA_W-1:0] In_data,
  output logic              Out_valid,
  output logic [7:0]        Out_data,
  input  logic              Out_ready,
  output logic [ADDR_W:0]   Level,
  output logic              Overflow
);
  typedef enum logic [2:0] {IDLE, HI, LO
`ifdef SYNC_HEADER_EN
    , HDR1, HDR2
`endif
  } state_t;
  state_t state, state_n;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] sample;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic empty, full, pop, wr, valid_n;
  logic [7:0] data_n;
  assign empty = Level == '0;
  assign full = Level == (ADDR_W+1)'(DEPTH);
  // a pop frees a slot in the same cycle, so a write into a full FIFO still lands
  assign wr = In_valid && (!full || pop);
`ifdef SYNC_HEADER_EN
  localparam int FW = $clog2(FRAME_LEN);
  logic [FW-1:0] frame_cnt;
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) frame_cnt <= '0;
    else if (pop) frame_cnt <= (frame_cnt == FW'(FRAME_LEN-1)) ? '0 : frame_cnt + 1'b1;
`endif
  always_comb begin
    state_n = state;
    valid_n = Out_valid;
    data_n = Out_data;
    pop = 1'b0;
    case (state)
      IDLE: pop = !empty;
      HI: if (Out_ready) begin
        state_n = LO;
        data_n = sample[7:0];
      end
      LO: if (Out_ready) begin
        pop = !empty;
        state_n = IDLE;
        valid_n = 1'b0;
      end
`ifdef SYNC_HEADER_EN
      HDR1: if (Out_ready) begin
        state_n = HDR2;
        data_n = 8'h5A;
      end
      HDR2: if (Out_ready) begin
        state_n = HI;
        data_n = sample[DATA_W-1 -: 8];
      end
`endif
      default: ;
    endcase
    if (pop) begin
      valid_n = 1'b1;
`ifdef SYNC_HEADER_EN
      state_n = (frame_cnt == '0) ? HDR1 : HI;
      data_n = (frame_cnt == '0) ? 8'hA5 : mem[rd_ptr][DATA_W-1 -: 8];
`else
      state_n = HI;
      data_n = mem[rd_ptr][DATA_W-1 -: 8];
`endif
    end
  end
  always_ff @(posedge Clk)
    if (wr) mem[wr_ptr] <= In_data;
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      state <= IDLE;
      Out_valid <= 1'b0;
      Out_data <= 8'h00;
      sample <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      Level <= '0;
      Overflow <= 1'b0;
    end else begin
      state <= state_n;
      Out_valid <= valid_n;
      Out_data <= data_n;
      if (pop) sample <= mem[rd_ptr];
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      Level <= Level + (ADDR_W+1)'(wr) - (ADDR_W+1)'(pop);
      if (In_valid && !wr) Overflow <= 1'b1;
    end
endmodule
